// File: rtl/fifo_pkg.sv
// Shared sizing and reset defaults for the per-lane threshold FIFOs.
// Also carries the lane count used by the control FSM's empty_fifos vector.
package fifo_pkg;

    localparam int DATA_W  = 6;
    localparam int DEPTH   = 8;
    localparam int PTR_W   = 3;
    localparam int CNT_W   = 4;
    localparam int N_LANES = 8;

    localparam logic [2:0]       ALTO_DEF = 3'd6;
    localparam logic [2:0]       BAJO_DEF = 3'd1;
    localparam logic [CNT_W-1:0] FULL_CNT = 4'd8;

endpackage

// File: rtl/memoria_fifo.sv
// FIFO storage: DEPTH x DATA_W registers, synchronous write, combinational read.
// No reset; contents are undefined until written.
module memoria_fifo
    import fifo_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [PTR_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [PTR_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_umbrales.sv
// Per-lane FIFO with programmable almost-full/almost-empty thresholds.
// Define FIFO_ERROR_EN to build the sticky overflow/underflow flag.
module fifo_umbrales
    import fifo_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              rd_en,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    input  logic              cfg_valid,
    input  logic [2:0]        umbral_bajo,
    input  logic [2:0]        umbral_alto,
    output logic              empty,
    output logic              full,
    output logic              almost_empty,
    output logic              almost_full,
    output logic              fifo_error
);

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [2:0]        alto_reg;
    logic [2:0]        bajo_reg;
    logic [DATA_W-1:0] rd_data;
    logic              push;
    logic              pop;

    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push = wr_en && (!full || rd_en);
    assign pop  = rd_en && !empty;

    memoria_fifo u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (data_in),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 3'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 3'd1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out  <= '0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= pop;
            if (pop) begin
                data_out <= rd_data;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alto_reg <= ALTO_DEF;
            bajo_reg <= BAJO_DEF;
        end else if (cfg_valid) begin
            alto_reg <= umbral_alto;
            bajo_reg <= umbral_bajo;
        end
    end

    assign empty        = (count == '0);
    assign full         = (count == FULL_CNT);
    assign almost_empty = (count <= {1'b0, bajo_reg});
    assign almost_full  = (count >= {1'b0, alto_reg});

`ifdef FIFO_ERROR_EN
    logic err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if ((wr_en && full && !rd_en) || (rd_en && empty)) begin
            err_q <= 1'b1;
        end
    end

    assign fifo_error = err_q;
`else
    assign fifo_error = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_umbrales.sv
// Self-checking bench for fifo_umbrales using a queue scoreboard.
// Error expectations follow FIFO_ERROR_EN.
module tb_fifo_umbrales;

`ifdef FIFO_ERROR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic [5:0] data_in = '0;
    logic       rd_en = 1'b0;
    logic [5:0] data_out;
    logic       valid_out;
    logic       cfg_valid = 1'b0;
    logic [2:0] umbral_bajo = '0;
    logic [2:0] umbral_alto = '0;
    logic       empty;
    logic       full;
    logic       almost_empty;
    logic       almost_full;
    logic       fifo_error;

    int checks = 0;
    int errors = 0;

    logic [5:0] sb[$];
    int         m_cnt;
    logic [2:0] m_alto;
    logic [2:0] m_bajo;
    logic [5:0] exp_data;
    logic       exp_valid;
    logic       exp_err;

    always #5 clk = ~clk;

    fifo_umbrales dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .data_in      (data_in),
        .rd_en        (rd_en),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .cfg_valid    (cfg_valid),
        .umbral_bajo  (umbral_bajo),
        .umbral_alto  (umbral_alto),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .fifo_error   (fifo_error)
    );

    function automatic logic [3:0] model_flags();
        return {m_cnt == 0, m_cnt == 8,
                m_cnt <= int'(m_bajo), m_cnt >= int'(m_alto)};
    endfunction

    task automatic model_reset();
        sb.delete();
        m_cnt     = 0;
        m_alto    = 3'd6;
        m_bajo    = 3'd1;
        exp_data  = '0;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic step(input logic w, input logic [5:0] d, input logic r);
        logic push_ok;
        logic pop_ok;
        @(negedge clk);
        wr_en   = w;
        data_in = d;
        rd_en   = r;
        push_ok = w && (m_cnt < 8 || r);
        pop_ok  = r && m_cnt != 0;
        exp_valid = pop_ok;
        if (pop_ok) exp_data = sb.pop_front();
        if (push_ok) sb.push_back(d);
        if ((w && !push_ok) || (r && !pop_ok)) exp_err = ERR_EN;
        m_cnt = sb.size();
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic cfg(input logic [2:0] alto, input logic [2:0] bajo);
        @(negedge clk);
        cfg_valid   = 1'b1;
        umbral_alto = alto;
        umbral_bajo = bajo;
        m_alto      = alto;
        m_bajo      = bajo;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({empty, full, almost_empty, almost_full} !== 4'b1010) begin
            errors++;
            $display("FAIL reset_flags got %b want 1010",
                     {empty, full, almost_empty, almost_full});
        end
        checks++;
        if (valid_out !== 1'b0 || data_out !== 6'h00 || fifo_error !== 1'b0) begin
            errors++;
            $display("FAIL reset_out got v=%b d=%h e=%b want 0 00 0",
                     valid_out, data_out, fifo_error);
        end
    endtask

    task automatic test_fill();
        logic [3:0] want;
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 6'(i), 1'b0);
            want = {1'b0, i == 8, i < 2, i >= 6};
            checks++;
            if ({empty, full, almost_empty, almost_full} !== want) begin
                errors++;
                $display("FAIL fill_flags_%0d got %b want %b", i,
                         {empty, full, almost_empty, almost_full}, want);
            end
        end
        step(1'b1, 6'h3F, 1'b0);
        checks++;
        if (full !== 1'b1 || fifo_error !== exp_err) begin
            errors++;
            $display("FAIL overflow got full=%b err=%b want 1 %b",
                     full, fifo_error, exp_err);
        end
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 6'h00, 1'b1);
            checks++;
            if (valid_out !== 1'b1 || data_out !== exp_data
                || exp_data !== 6'(i)) begin
                errors++;
                $display("FAIL drain_%0d got v=%b d=%h want 1 %h",
                         i, valid_out, data_out, 6'(i));
            end
        end
        checks++;
        if (model_flags() !== 4'b1010 ||
            {empty, full, almost_empty, almost_full} !== 4'b1010) begin
            errors++;
            $display("FAIL drained_flags got %b want 1010",
                     {empty, full, almost_empty, almost_full});
        end
        step(1'b0, 6'h00, 1'b1);
        checks++;
        if (valid_out !== 1'b0 || data_out !== 6'h08 || fifo_error !== exp_err) begin
            errors++;
            $display("FAIL extra_pop got v=%b d=%h e=%b want 0 08 %b",
                     valid_out, data_out, fifo_error, exp_err);
        end
    endtask

    task automatic test_full_rw();
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 6'(6'h10 + i), 1'b0);
        for (int i = 0; i < 9; i++) begin
            step(1'b1, (i == 0) ? 6'h2A : 6'(6'h20 + i), 1'b1);
            checks++;
            if (valid_out !== 1'b1 || data_out !== exp_data || full !== 1'b1
                || fifo_error !== 1'b0) begin
                errors++;
                $display("FAIL full_rw_%0d got v=%b d=%h f=%b e=%b want 1 %h 1 0",
                         i, valid_out, data_out, full, fifo_error, exp_data);
            end
        end
        checks++;
        if (exp_data !== 6'h2A) begin
            errors++;
            $display("FAIL full_rw_order got %h want 2a", exp_data);
        end
    endtask

    task automatic test_empty_rw();
        do_reset();
        step(1'b1, 6'h15, 1'b1);
        checks++;
        if (valid_out !== 1'b0 || empty !== 1'b0 || data_out !== 6'h00) begin
            errors++;
            $display("FAIL empty_rw got v=%b e=%b d=%h want 0 0 00",
                     valid_out, empty, data_out);
        end
        step(1'b0, 6'h00, 1'b1);
        checks++;
        if (valid_out !== 1'b1 || data_out !== 6'h15) begin
            errors++;
            $display("FAIL empty_rw_pop got v=%b d=%h want 1 15",
                     valid_out, data_out);
        end
    endtask

    task automatic test_cfg();
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 6'(i + 1), 1'b0);
        checks++;
        if (almost_full !== 1'b0 || almost_empty !== 1'b0) begin
            errors++;
            $display("FAIL cfg_before got af=%b ae=%b want 0 0",
                     almost_full, almost_empty);
        end
        cfg(3'd3, 3'd2);
        checks++;
        if (almost_full !== 1'b1 || almost_empty !== 1'b0) begin
            errors++;
            $display("FAIL cfg_3_2 got af=%b ae=%b want 1 0",
                     almost_full, almost_empty);
        end
        cfg(3'd0, 3'd7);
        checks++;
        if (almost_full !== 1'b1 || almost_empty !== 1'b1) begin
            errors++;
            $display("FAIL cfg_0_7 got af=%b ae=%b want 1 1",
                     almost_full, almost_empty);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 6'h00, 1'b1);
        checks++;
        if ({empty, full, almost_empty, almost_full} !== model_flags()
            || model_flags() !== 4'b1011) begin
            errors++;
            $display("FAIL cfg_alto0_empty got %b want 1011",
                     {empty, full, almost_empty, almost_full});
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 6'(6'h30 + i), 1'b0);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({empty, full, almost_empty, almost_full} !== 4'b1010) begin
            errors++;
            $display("FAIL async_reset_flags got %b want 1010",
                     {empty, full, almost_empty, almost_full});
        end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        step(1'b1, 6'h0C, 1'b0);
        step(1'b0, 6'h00, 1'b1);
        checks++;
        if (valid_out !== 1'b1 || data_out !== 6'h0C || data_out !== exp_data) begin
            errors++;
            $display("FAIL async_reset_data got v=%b d=%h want 1 0c",
                     valid_out, data_out);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_fill();
        test_drain();
        test_full_rw();
        test_empty_rw();
        test_cfg();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
